// File: rtl/chart_sequencer.sv
// chart_sequencer: counts in on quarter strobes, then plays one chart ROM step per
// sixteenth strobe and presents non-empty steps as arrow events on valid/ready.
module chart_sequencer #(
  parameter int ADDR_W = 8,
  parameter int CHART_LEN = 256,
  parameter int COUNT_IN_BEATS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              abort_i,
  input  logic              quarter_i,
  input  logic              sixteenth_i,
  output logic [ADDR_W-1:0] chart_addr_o,
  input  logic [4:0]        chart_data_i,
  output logic              arrow_valid_o,
  output logic [3:0]        arrow_mask_o,
  input  logic              arrow_ready_i,
  output logic              beat_o,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic              overrun_o
);
  localparam int CW = $clog2(COUNT_IN_BEATS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_LEN - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(COUNT_IN_BEATS - 1);
  typedef enum logic [2:0] {IDLE, COUNT_IN, PLAY, PAUSE, DONE} state_t;
  state_t state;
  logic [CW-1:0] beats;
  logic [3:0] mask;
  assign mask = chart_data_i[3:0];
  assign state_o = state;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      beats <= '0;
      chart_addr_o <= '0;
      arrow_valid_o <= 1'b0;
      arrow_mask_o <= '0;
      beat_o <= 1'b0;
      done_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      beat_o <= quarter_i && (state == COUNT_IN || state == PLAY);
      if (arrow_valid_o && arrow_ready_i) arrow_valid_o <= 1'b0;
      if (abort_i) begin
        state <= IDLE;
        beats <= '0;
        chart_addr_o <= '0;
        arrow_valid_o <= 1'b0;
        done_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            chart_addr_o <= '0;
            beats <= '0;
            if (start_i) begin
              state <= COUNT_IN;
              overrun_o <= 1'b0;
            end
          end
          COUNT_IN: begin
            if (quarter_i) begin
              state <= beats == LAST_BEAT ? PLAY : COUNT_IN;
              beats <= beats == LAST_BEAT ? '0 : beats + 1'b1;
            end
          end
          PLAY: begin
            if (pause_i) state <= PAUSE;
            else if (sixteenth_i) begin
              if (chart_data_i[4]) begin
                state <= DONE;
                done_o <= 1'b1;
              end else begin
                // a retiring event frees the slot in the same cycle
                if (mask != '0 && (!arrow_valid_o || arrow_ready_i)) begin
                  arrow_valid_o <= 1'b1;
                  arrow_mask_o <= mask;
                end else if (mask != '0) overrun_o <= 1'b1;
                if (chart_addr_o == LAST_ADDR) begin
                  state <= DONE;
                  done_o <= 1'b1;
                end else chart_addr_o <= chart_addr_o + 1'b1;
              end
            end
          end
          PAUSE: if (!pause_i) state <= PLAY;
          DONE: begin
            if (start_i) begin
              state <= COUNT_IN;
              chart_addr_o <= '0;
              overrun_o <= 1'b0;
              done_o <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chart_sequencer.sv
// tb_chart_sequencer: directed chart scenarios; accepted arrow events are checked
// against a queue of expected masks by a free-running monitor.
module tb_chart_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic quarter = 1'b0, sixteenth = 1'b0, ready = 1'b0;
  logic [7:0] addr;
  logic [4:0] data;
  logic valid, beat, done, overrun;
  logic [3:0] mask;
  logic [2:0] state;
  logic [1:0] addr4;
  logic [4:0] data4;
  logic valid4, beat4, done4, overrun4;
  logic [3:0] mask4;
  logic [2:0] state4;
  logic [4:0] rom [256];
  logic [4:0] rom4 [4];
  logic [3:0] exp_q [$];
  logic [3:0] exp_mask;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) data <= rom[addr];
  always @(posedge clk) data4 <= rom4[addr4];

  chart_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .abort_i(abort),
    .quarter_i(quarter), .sixteenth_i(sixteenth), .chart_addr_o(addr), .chart_data_i(data),
    .arrow_valid_o(valid), .arrow_mask_o(mask), .arrow_ready_i(ready), .beat_o(beat),
    .state_o(state), .done_o(done), .overrun_o(overrun)
  );

  chart_sequencer #(.ADDR_W(2), .CHART_LEN(4), .COUNT_IN_BEATS(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .abort_i(abort),
    .quarter_i(quarter), .sixteenth_i(sixteenth), .chart_addr_o(addr4), .chart_data_i(data4),
    .arrow_valid_o(valid4), .arrow_mask_o(mask4), .arrow_ready_i(ready), .beat_o(beat4),
    .state_o(state4), .done_o(done4), .overrun_o(overrun4)
  );

  // scoreboard monitor: every accepted event must match the oldest expected mask
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL arrow_event: got mask %h, none expected", mask);
      end else begin
        exp_mask = exp_q.pop_front();
        if (mask !== exp_mask) begin
          errors++;
          $display("FAIL arrow_event: got mask %h, expected %h", mask, exp_mask);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (3) tick();
  endtask

  task automatic step();
    sixteenth = 1'b1;
    tick();
    sixteenth = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic count_in();
    repeat (4) begin
      quarter = 1'b1;
      tick();
      quarter = 1'b0;
      tick();
    end
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 5'h00;
  endtask

  initial begin
    clear_rom();
    rom4[0] = 5'h1; rom4[1] = 5'h2; rom4[2] = 5'h3; rom4[3] = 5'h4;
    rom[0] = 5'h01; rom[1] = 5'h00; rom[2] = 5'h06; rom[3] = 5'h10;
    tick();
    tick();
    chk("reset_state", state, 0);
    chk("reset_addr", addr, 0);
    chk("reset_valid", valid, 0);
    chk("reset_beat", beat, 0);
    chk("reset_done", done, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();
    // count-in with sixteenths interleaved
    pulse_start();
    chk("countin_state", state, 1);
    for (int i = 0; i < 4; i++) begin
      quarter = 1'b1;
      tick();
      quarter = 1'b0;
      chk("countin_beat", beat, 1);
      chk("countin_state_q", state, i == 3 ? 2 : 1);
      tick();
      chk("countin_beat_off", beat, 0);
      if (i < 3) begin
        step();
        chk("countin_no_valid", valid, 0);
        chk("countin_addr", addr, 0);
        gap();
      end
    end
    // basic playback, ready tied high
    ready = 1'b1;
    gap();
    exp_q.push_back(4'h1);
    step();
    chk("play0_valid", valid, 1);
    chk("play0_mask", mask, 4'h1);
    chk("play0_addr", addr, 1);
    tick();
    chk("play0_valid_1cyc", valid, 0);
    gap();
    step();
    chk("play1_empty", valid, 0);
    chk("play1_addr", addr, 2);
    gap();
    exp_q.push_back(4'h6);
    step();
    chk("play2_valid", valid, 1);
    chk("play2_mask", mask, 4'h6);
    chk("play2_addr", addr, 3);
    tick();
    chk("play2_valid_1cyc", valid, 0);
    gap();
    step();
    chk("play_end_state", state, 4);
    chk("play_end_done", done, 1);
    chk("play_end_addr", addr, 3);
    gap();
    step();
    chk("play_end_hold", addr, 3);
    // backpressure and overrun
    ready = 1'b0;
    clear_rom();
    rom[0] = 5'h08; rom[1] = 5'h04; rom[2] = 5'h02; rom[3] = 5'h01; rom[4] = 5'h10;
    pulse_start();
    chk("restart_state", state, 1);
    chk("restart_addr", addr, 0);
    chk("restart_done", done, 0);
    count_in();
    chk("bp_play", state, 2);
    exp_q.push_back(4'h8);
    step();
    chk("bp0_mask", mask, 4'h8);
    chk("bp0_overrun", overrun, 0);
    gap();
    step();
    chk("bp1_valid", valid, 1);
    chk("bp1_mask", mask, 4'h8);
    chk("bp1_overrun", overrun, 1);
    gap();
    step();
    chk("bp2_mask", mask, 4'h8);
    chk("bp2_addr", addr, 3);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("bp_retired", valid, 0);
    gap();
    // abort with an event pending
    exp_q.push_back(4'h1);
    step();
    chk("pend_valid", valid, 1);
    chk("pend_mask", mask, 4'h1);
    pulse_abort();
    exp_q.delete();
    chk("abort_state", state, 0);
    chk("abort_valid", valid, 0);
    chk("abort_addr", addr, 0);
    chk("abort_overrun", overrun, 1);
    // same-cycle retire and load
    clear_rom();
    rom[0] = 5'h01; rom[1] = 5'h02; rom[2] = 5'h04; rom[3] = 5'h10;
    pulse_start();
    chk("start_clr_overrun", overrun, 0);
    count_in();
    exp_q.push_back(4'h1);
    step();
    chk("sc0_mask", mask, 4'h1);
    gap();
    exp_q.push_back(4'h2);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("sc1_valid", valid, 1);
    chk("sc1_mask", mask, 4'h2);
    chk("sc1_overrun", overrun, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("sc_retired", valid, 0);
    // pause at step 5
    clear_rom();
    rom[5] = 5'h03; rom[6] = 5'h10;
    pulse_abort();
    pulse_start();
    count_in();
    ready = 1'b1;
    repeat (5) begin
      gap();
      step();
    end
    chk("pause_pre_addr", addr, 5);
    gap();
    pause = 1'b1;
    tick();
    chk("pause_state", state, 3);
    repeat (3) begin
      gap();
      step();
      chk("pause_addr", addr, 5);
      chk("pause_valid", valid, 0);
    end
    pause = 1'b0;
    tick();
    chk("unpause_state", state, 2);
    gap();
    exp_q.push_back(4'h3);
    step();
    chk("unpause_mask", mask, 4'h3);
    chk("unpause_addr", addr, 6);
    tick();
    chk("unpause_retired", valid, 0);
    // end of chart without an end marker on the 4-step instance
    pulse_abort();
    chk("len4_idle", state4, 0);
    pulse_start();
    count_in();
    for (int i = 0; i < 4; i++) begin
      gap();
      step();
      chk("len4_addr", addr4, i < 3 ? i + 1 : 3);
      chk("len4_state", state4, i < 3 ? 2 : 4);
    end
    chk("len4_done", done4, 1);
    gap();
    step();
    chk("len4_no_wrap", addr4, 3);
    ready = 1'b0;
    gap();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chart_sequencer.md
# chart_sequencer

Steps a dance chart in time with the song tempo. Waits for a start request, counts in a fixed number of quarter-note strobes from the timing generator, then reads one chart step per sixteenth strobe from a synchronous chart ROM. Each non-empty step becomes an arrow-spawn event on a valid/ready handshake to the arrow spawner. Sits between the timing generator and the arrow spawner/scoring logic, and supports pause, abort and end-of-chart detection.

## Interface
- ADDR_W, 8, chart ROM address width
- CHART_LEN, 256, number of steps in the chart; must satisfy 1 ≤ CHART_LEN ≤ 2^ADDR_W
- COUNT_IN_BEATS, 4, quarter strobes counted before step 0; must be ≥ 1
- clk_i  in  1  system clock
- rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  one-cycle start/restart request
- pause_i  in  1  level; holds playback while high
- abort_i  in  1  one-cycle abort request
- quarter_i  in  1  one-cycle quarter-note strobe from the timing generator
- sixteenth_i  in  1  one-cycle step strobe from the timing generator
- chart_addr_o  out  ADDR_W  chart ROM address (current step index)
- chart_data_i  in  5  ROM word: bit4 = end marker; bits3:0 = arrow mask {left, down, up, right}
- arrow_valid_o  out  1  arrow event pending
- arrow_mask_o  out  4  arrow mask of the pending event
- arrow_ready_i  in  1  spawner accepts the event
- beat_o  out  1  quarter strobe delayed one cycle; asserted only in COUNT_IN or PLAY
- state_o  out  3  IDLE=0, COUNT_IN=1, PLAY=2, PAUSE=3, DONE=4
- done_o  out  1  high while in DONE
- overrun_o  out  1  sticky flag: a step was dropped because the previous event was still pending

## Operation
- **ROM interface.** The ROM has 1-cycle read latency. chart_addr_o changes only on a consumed sixteenth strobe. Strobes are many cycles apart, so chart_data_i is always stable when it is sampled.
- **IDLE**
  - chart_addr_o = 0; the count-in counter is cleared.
  - start_i → COUNT_IN.
- **COUNT_IN**
  - Each quarter_i increments the beat counter.
  - The quarter_i that makes the count equal COUNT_IN_BEATS → PLAY and clears the counter.
  - sixteenth_i is ignored in this state.
- **PLAY**, on each sixteenth_i:
  - If chart_data_i[4] = 1: go to DONE. No event is generated and the address does not advance.
  - Else, if mask ≠ 0 and arrow_valid_o = 0: load arrow_mask_o and set arrow_valid_o on the next cycle.
  - Else, if mask ≠ 0 and arrow_valid_o = 1: drop the step and set overrun_o.
  - A zero mask generates no event.
  - If chart_addr_o = CHART_LEN−1: go to DONE after processing the step; the address does not wrap.
  - Otherwise chart_addr_o increments by 1.
- **PAUSE**
  - pause_i high in PLAY → PAUSE. pause_i low in PAUSE → PLAY.
  - In PAUSE, sixteenth_i and quarter_i are ignored and the address is frozen.
  - A pending event stays valid and can still be accepted.
- **DONE**
  - done_o = 1.
  - start_i → COUNT_IN with chart_addr_o = 0 and overrun_o cleared.
- **Handshake**
  - arrow_valid_o stays high, with arrow_mask_o stable, until a cycle in which arrow_ready_i = 1. It drops on the following cycle.
  - The pending event survives the transition to DONE.
- **Abort**
  - abort_i in any state → IDLE on the next cycle.
  - Clears arrow_valid_o, chart_addr_o and the beat counter. overrun_o is held.
- **Start**
  - start_i also clears overrun_o.
  - start_i is ignored in COUNT_IN, PLAY and PAUSE.
- **Priority:** rst_ni > abort_i > start_i > pause_i > strobes.

## Timing
- **Reset.** While rst_ni = 0 at a clock edge:
  - state = IDLE;
  - chart_addr_o, arrow_valid_o, arrow_mask_o, beat_o, done_o, overrun_o = 0;
  - state_o = 0.
- **Registered outputs.** All outputs are registered. State changes are visible one cycle after the triggering input.
- **Step latency.** sixteenth_i at cycle N:
  - arrow_valid_o, arrow_mask_o and the chart_addr_o increment are visible at N+1;
  - the ROM word for the new address is valid at N+2.
- **Same-cycle handshake.** If arrow_ready_i = 1 and a new non-empty step are in the same cycle as a pending event, the old event retires and the new one loads. arrow_valid_o stays high and no overrun is flagged.
- **Quarter and sixteenth together.**
  - On the final count-in beat, the state goes to PLAY and the coincident sixteenth is not consumed. Step 0 is sampled on the next sixteenth_i.
  - In PLAY, beat_o pulses and the step is processed in the same cycle.
- **Pause and strobe together.** pause_i rising in the same cycle as sixteenth_i enters PAUSE; the step is not consumed.
- **Reset mid-operation.** Drops any pending event immediately, without a handshake.

## Test plan
- **Count-in.** Reset, start_i, then 4 quarter_i pulses with a sixteenth between each. Required:
  - state_o = 1 until the 4th quarter, then 2;
  - beat_o pulses 4 times;
  - no arrow_valid_o during count-in.
- **Basic playback.** Chart {0x1, 0x0, 0x6, 0x10}, ready tied high. Required:
  - events 0x1 then 0x6, each valid for exactly 1 cycle;
  - chart_addr_o stops at 3;
  - done_o = 1 after the 4th sixteenth.
- **Backpressure and overrun.** Chart {0x8, 0x4, 0x2}, ready low until after the 3rd step. Required:
  - 0x8 is held stable throughout;
  - overrun_o = 1 after step 1;
  - 0x4 and 0x2 are never presented.
- **Same-cycle retire and load.** Ready pulsed in the same cycle as a new step. Required: back-to-back events with no gap in arrow_valid_o and overrun_o = 0.
- **Pause.** pause_i held across 3 sixteenth strobes at step 5. Required:
  - state_o = 3;
  - chart_addr_o stays 5;
  - after release, step 5 is processed on the next sixteenth.
- **Abort and end of chart.**
  - abort_i mid-PLAY with an event pending: next cycle state_o = 0, arrow_valid_o = 0, chart_addr_o = 0, and overrun_o is unchanged.
  - CHART_LEN = 4 with no end marker: DONE after step 3, and the address does not wrap.
